fnd_page_scanner: RTL and testbench
===================================

// Module: fnd_page_scanner
// PURPOSE
//  Parametrised N-digit 7-segment scan engine with multi-page rotation, replacing per-mode auto/manual toggle logic.
//  Upstream formatters drive raw active-low segment patterns for up to NUM_PAGES pages.
//  This block rotates enabled pages on a dwell timer and multiplexes the digits, with forced page, PWM brightness and per-digit blink.
//  It sits between the mode/formatter logic and the board FND pins.
// PARAMETERS
//  NUM_DIGITS  4            digits on the display (2..8)
//  NUM_PAGES   4            selectable pages (1..8)
//  SCAN_DIV    100_000      clk cycles per digit slot (1 ms at 100 MHz); must be a multiple of 8
//  DWELL_CYC   300_000_000  clk cycles a page is shown before rotating (3 s)
//  BLINK_DIV   50_000_000   clk cycles per blink half-phase (0.5 s)
//  BLANK_CYC   16           anti-ghost blank cycles at the start of each digit slot (< SCAN_DIV/8)
//  PW          $clog2(NUM_PAGES), min 1 (localparam)
// PORTS
//  clk             in   1                     system clock
//  reset           in   1                     synchronous, active-high
//  page_seg        in   NUM_PAGES*NUM_DIGITS*8  raw patterns, active-low, dp=bit7; page p digit d at [(p*NUM_DIGITS+d)*8 +: 8]; digit 0 = rightmost
//  page_en         in   NUM_PAGES             page participates in rotation
//  page_hold       in   1                     freeze rotation (dwell counter holds)
//  page_force      in   1                     override: show page_force_idx
//  page_force_idx  in   PW                    forced page index
//  blink_mask      in   NUM_DIGITS            digit blanks during blink-off phase
//  bright          in   3                     duty = (bright+1)/8 of each digit slot
//  an              out  NUM_DIGITS            digit enables, active-low, registered
//  seg             out  8                     segment data, active-low, registered
//  cur_page        out  PW                    page currently displayed
//  page_valid      out  1                     1 = a page is displayed (not IDLE)
//  page_tick       out  1                     1-cycle pulse when cur_page changes
// BEHAVIOUR
//  Reset: an = all 1, seg = 8'hFF, cur_page = 0, page_valid = 0, page_tick = 0, all counters 0, blink phase = on, state = IDLE.
//  Scan
//   - scan_cnt counts 0..SCAN_DIV-1; on wrap, dig advances 0..NUM_DIGITS-1 and wraps to 0.
//   - sub = scan_cnt / (SCAN_DIV/8).
//   - Digit on when: scan_cnt >= BLANK_CYC, sub <= bright, page_valid, and not (blink_mask[dig] & blink_off).
//   - On: an = ~(1<<dig), seg = page_seg[cur_page][dig]. Otherwise an = all 1, seg = 8'hFF.
//   - Outputs are registered: 1-cycle latency from counter/index to pins.
//   - Blink phase toggles every BLINK_DIV cycles, free-running.
//  Rotation FSM (IDLE, SHOW, FORCE)
//   - IDLE: page_en == 0 and !page_force. Outputs blank.
//     Leaving IDLE: cur_page = lowest enabled index, dwell = 0, page_tick pulses.
//   - SHOW: dwell counts when !page_hold.
//     At dwell == DWELL_CYC-1: cur_page = next enabled index after cur_page, round-robin with wrap; dwell = 0; page_tick pulses.
//     If only one page is enabled: no change and no tick.
//   - SHOW, current page disabled mid-dwell: advance to next enabled page on the following cycle, dwell = 0.
//     If none remain enabled: go to IDLE, page_valid = 0.
//   - FORCE: entered from any state while page_force = 1. cur_page = page_force_idx (idx >= NUM_PAGES is clamped to NUM_PAGES-1); page_en is ignored; dwell is held at 0.
//     Changing idx while forced updates cur_page next cycle with page_tick.
//     Release: go to SHOW if page_en != 0 (keep cur_page if enabled, else next enabled), else IDLE.
//   - Priority: reset > page_force > page disabled > dwell expiry. page_hold does not block a disable-advance.
//   - page_tick fires only when cur_page actually changes value or page_valid rises.
//  The page change takes effect on seg at the next digit output update. No mid-slot tearing is required beyond that.
//  Reset mid-operation: all state returns to reset values on the next edge, regardless of the inputs.
// STRUCTURE
//  Package fnd_pkg: SEG_BLANK = 8'hFF, digit glyph constants 0-9 and A/C/E/H/L/O/P/S/T/U, state enum {IDLE, SHOW, FORCE}.
//  Sub-module fnd_rr_next: combinational round-robin finder.
//   - Inputs: en[NUM_PAGES], start[PW].
//   - Outputs: nxt[PW], any (first set bit strictly after start, wrapping).
//   - Used for both the dwell advance and the disable advance.
//  Top level: scan/PWM counters, blink divider, rotation FSM, output registers.
// TESTING  (NUM_DIGITS=4, NUM_PAGES=4, SCAN_DIV=32, DWELL_CYC=200, BLINK_DIV=100, BLANK_CYC=2)
//  1 Reset held 3 cycles with any inputs -> an=4'b1111, seg=8'hFF, cur_page=0, page_valid=0, page_tick=0.
//  2 page_en=4'b0001, bright=7, page0 = digits 0xC0,0xF9,0xA4,0xB0 ->
//    - an steps 1110,1101,1011,0111, each on for cycles 2..31 of its 32-cycle slot;
//    - seg matches the digit pattern, lagging the counters by 1 cycle.
//  3 page_en=4'b1011 -> cur_page sequence 0,1,3,0 every 200 cycles, one page_tick per change; page_hold=1 freezes it.
//  4 Show page 1, clear page_en[1] mid-dwell -> cur_page=3 next cycle with tick.
//    Then page_en=0 -> IDLE, an all 1. Then page_en=4'b0100 -> cur_page=2, tick.
//  5 page_force=1, idx=2 while page_en=4'b0001 -> cur_page=2 next cycle with tick; no rotation while forced.
//    Release -> cur_page=0 with tick, dwell restarts from 0.
//  6 bright=1 -> an low only for sub 0..1 (scan_cnt 2..7).
//    blink_mask=4'b0010 -> digit 1 blank for alternating 100-cycle phases while the other digits keep scanning.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the FND page scanner: blank pattern, active-low
// 7-segment glyphs (dp = bit 7, a = bit 0) and the rotation state type.
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_H = 8'h89;
  localparam logic [7:0] GLYPH_L = 8'hC7;
  localparam logic [7:0] GLYPH_O = 8'hC0;
  localparam logic [7:0] GLYPH_P = 8'h8C;
  localparam logic [7:0] GLYPH_S = 8'h92;
  localparam logic [7:0] GLYPH_T = 8'h87;
  localparam logic [7:0] GLYPH_U = 8'hC1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    FORCE = 2'd2
  } fnd_state_e;

endpackage

// File: rtl/fnd_rr_next.sv
// Combinational round-robin finder: first enabled index strictly after
// start, wrapping; start itself is the last candidate so a lone enabled
// page maps onto itself.
module fnd_rr_next #(
  parameter int NUM_PAGES = 4,
  parameter int PW        = 2
) (
  input  logic [NUM_PAGES-1:0] en,
  input  logic [PW-1:0]        start,
  output logic [PW-1:0]        nxt,
  output logic                 any
);

  int idx;

  // Scan from the farthest candidate down so the nearest enabled one wins.
  always_comb begin
    nxt = start;
    any = |en;
    idx = 0;
    for (int k = NUM_PAGES; k >= 1; k--) begin
      idx = (int'(start) + k) % NUM_PAGES;
      if (en[idx]) nxt = PW'(idx);
    end
  end

endmodule

// File: rtl/fnd_page_scanner.sv
// N-digit 7-segment scan engine with timed page rotation, forced page,
// PWM brightness and per-digit blink. All pins are registered.
module fnd_page_scanner
  import fnd_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int NUM_PAGES  = 4,
  parameter  int SCAN_DIV   = 100_000,
  parameter  int DWELL_CYC  = 300_000_000,
  parameter  int BLINK_DIV  = 50_000_000,
  parameter  int BLANK_CYC  = 16,
  localparam int PW         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PAGES*NUM_DIGITS*8-1:0] page_seg,
  input  logic [NUM_PAGES-1:0]            page_en,
  input  logic                            page_hold,
  input  logic                            page_force,
  input  logic [PW-1:0]                   page_force_idx,
  input  logic [NUM_DIGITS-1:0]           blink_mask,
  input  logic [2:0]                      bright,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [7:0]                      seg,
  output logic [PW-1:0]                   cur_page,
  output logic                            page_valid,
  output logic                            page_tick
);

  localparam int SLOT = SCAN_DIV / 8;
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int SLW  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int DW   = $clog2(NUM_DIGITS);
  localparam int DWW  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0]  scan_cnt;
  logic [SLW-1:0] slot_cnt;
  logic [2:0]     sub;
  logic [DW-1:0]  dig;
  logic [BW-1:0]  blink_cnt;
  logic           blink_off;
  logic [DWW-1:0] dwell;
  fnd_state_e     state;

  logic [PW-1:0]  rr_start;
  logic [PW-1:0]  rr_nxt;
  logic           rr_any;
  logic [PW-1:0]  force_idx;
  logic           digit_on;
  logic [7:0]     seg_sel;

  // The sub-slot index is kept as its own counter so no divider is needed
  // for non-power-of-two slot lengths.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      slot_cnt <= '0;
      sub      <= '0;
      dig      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      slot_cnt <= '0;
      sub      <= '0;
      dig      <= (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
      if (slot_cnt == SLW'(SLOT - 1)) begin
        slot_cnt <= '0;
        sub      <= sub + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + SLW'(1);
      end
    end
  end

  // Free-running blink phase; it never synchronises to the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // From IDLE the search starts after the top index so it yields the lowest
  // enabled page; otherwise it is relative to the page on display.
  assign rr_start  = (state == IDLE) ? PW'(NUM_PAGES - 1) : cur_page;
  assign force_idx = (int'(page_force_idx) > NUM_PAGES - 1) ? PW'(NUM_PAGES - 1)
                                                            : page_force_idx;

  fnd_rr_next #(
    .NUM_PAGES (NUM_PAGES),
    .PW        (PW)
  ) u_rr_next (
    .en    (page_en),
    .start (rr_start),
    .nxt   (rr_nxt),
    .any   (rr_any)
  );

  // Rotation FSM: force overrides everything, a disabled page advances
  // ahead of (and regardless of hold on) the dwell timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_page   <= '0;
      page_valid <= 1'b0;
      page_tick  <= 1'b0;
      dwell      <= '0;
    end else begin
      page_tick <= 1'b0;
      if (page_force) begin
        state      <= FORCE;
        dwell      <= '0;
        page_valid <= 1'b1;
        cur_page   <= force_idx;
        page_tick  <= (cur_page != force_idx) || !page_valid;
      end else begin
        case (state)
          IDLE: begin
            if (rr_any) begin
              state      <= SHOW;
              cur_page   <= rr_nxt;
              page_valid <= 1'b1;
              page_tick  <= 1'b1;
              dwell      <= '0;
            end
          end
          SHOW: begin
            if (!page_en[cur_page]) begin
              dwell <= '0;
              if (rr_any) begin
                cur_page  <= rr_nxt;
                page_tick <= 1'b1;
              end else begin
                state      <= IDLE;
                page_valid <= 1'b0;
              end
            end else if (!page_hold) begin
              if (dwell == DWW'(DWELL_CYC - 1)) begin
                dwell <= '0;
                if (rr_nxt != cur_page) begin
                  cur_page  <= rr_nxt;
                  page_tick <= 1'b1;
                end
              end else begin
                dwell <= dwell + DWW'(1);
              end
            end
          end
          FORCE: begin
            dwell <= '0;
            if (rr_any) begin
              state <= SHOW;
              if (!page_en[cur_page]) begin
                cur_page  <= rr_nxt;
                page_tick <= 1'b1;
              end
            end else begin
              state      <= IDLE;
              page_valid <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            page_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Digit gating: anti-ghost blank, PWM window, valid page and blink phase.
  always_comb begin
    digit_on = (scan_cnt >= SW'(BLANK_CYC)) && (sub <= bright) && page_valid &&
               !(blink_mask[dig] && blink_off);
    seg_sel  = page_seg[(int'(cur_page) * NUM_DIGITS + int'(dig)) * 8 +: 8];
  end

  // Pin registers: one cycle behind the counters and page index.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (digit_on) begin
      an  <= ~(NUM_DIGITS'(1) << dig);
      seg <= seg_sel;
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_fnd_page_scanner.sv
// Bench for fnd_page_scanner: directed steps plus randomized phases,
// checked every cycle against a time-based reference model.
module tb_fnd_page_scanner;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] page_seg;
  logic [3:0]   page_en;
  logic         page_hold;
  logic         page_force;
  logic [1:0]   page_force_idx;
  logic [3:0]   blink_mask;
  logic [2:0]   bright;
  logic [3:0]   an;
  logic [7:0]   seg;
  logic [1:0]   cur_page;
  logic         page_valid;
  logic         page_tick;

  int total = 0;
  int bad   = 0;

  fnd_page_scanner #(
    .NUM_DIGITS (4),
    .NUM_PAGES  (4),
    .SCAN_DIV   (32),
    .DWELL_CYC  (200),
    .BLINK_DIV  (100),
    .BLANK_CYC  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .page_seg       (page_seg),
    .page_en        (page_en),
    .page_hold      (page_hold),
    .page_force     (page_force),
    .page_force_idx (page_force_idx),
    .blink_mask     (blink_mask),
    .bright         (bright),
    .an             (an),
    .seg            (seg),
    .cur_page       (cur_page),
    .page_valid     (page_valid),
    .page_tick      (page_tick)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         mt;
  int         m_page;
  bit         m_valid;
  bit         m_forced;
  int         m_dwell;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic [1:0] exp_page;
  logic       exp_valid;
  logic       exp_tick;

  function automatic int next_after(input logic [3:0] en, input int p);
    for (int k = 1; k <= 4; k++)
      if (en[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  function automatic int lowest(input logic [3:0] en);
    for (int i = 0; i < 4; i++)
      if (en[i]) return i;
    return 0;
  endfunction

  // Counters are derived from elapsed cycles since reset; pages follow the
  // rotation rules directly.
  always @(posedge clk) begin : model
    int sc, dg, np, nd;
    bit bo, on, nv, nf, tk;
    sc = mt % 32;
    dg = (mt / 32) % 4;
    bo = ((mt / 100) % 2) == 1;
    on = (sc >= 2) && ((sc / 4) <= int'(bright)) && m_valid && !(blink_mask[dg] && bo);
    if (reset) begin
      exp_an <= 4'hF; exp_seg <= 8'hFF; exp_page <= 2'd0; exp_valid <= 1'b0; exp_tick <= 1'b0;
      mt <= 0; m_page <= 0; m_valid <= 1'b0; m_forced <= 1'b0; m_dwell <= 0;
    end else begin
      exp_an  <= on ? ~(4'b0001 << dg) : 4'hF;
      exp_seg <= on ? page_seg[(m_page * 4 + dg) * 8 +: 8] : 8'hFF;
      mt <= mt + 1;
      np = m_page; nv = m_valid; nf = m_forced; nd = m_dwell;
      if (page_force) begin
        np = (int'(page_force_idx) > 3) ? 3 : int'(page_force_idx);
        nv = 1'b1; nf = 1'b1; nd = 0;
      end else if (m_forced || !m_valid) begin
        nf = 1'b0; nd = 0;
        if (page_en == 4'd0) nv = 1'b0;
        else begin
          if (!m_valid) np = lowest(page_en);
          else if (!page_en[m_page]) np = next_after(page_en, m_page);
          nv = 1'b1;
        end
      end else if (!page_en[m_page]) begin
        nd = 0;
        if (page_en == 4'd0) nv = 1'b0;
        else np = next_after(page_en, m_page);
      end else if (!page_hold) begin
        if (m_dwell == 199) begin
          nd = 0;
          np = next_after(page_en, m_page);
        end else nd = m_dwell + 1;
      end
      tk = (nv && !m_valid) || (np != m_page);
      exp_page  <= 2'(np);
      exp_valid <= nv;
      exp_tick  <= tk;
      m_page <= np; m_valid <= nv; m_forced <= nf; m_dwell <= nd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("cur_page", 32'(cur_page), 32'(exp_page));
      chk("page_valid", 32'(page_valid), 32'(exp_valid));
      chk("page_tick", 32'(page_tick), 32'(exp_tick));
    end
  endtask

  task automatic rand_inputs();
    page_seg       = {$urandom, $urandom, $urandom, $urandom};
    page_en        = 4'($urandom_range(0, 15));
    page_hold      = 1'($urandom_range(0, 1));
    page_force     = 1'($urandom_range(0, 1));
    page_force_idx = 2'($urandom_range(0, 3));
    blink_mask     = 4'($urandom_range(0, 15));
    bright         = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int w;
    // Reset with arbitrary inputs
    rand_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h000000FF);
    chk("rst_page", 32'(cur_page), 32'd0);
    chk("rst_valid", 32'(page_valid), 32'd0);
    chk("rst_tick", 32'(page_tick), 32'd0);

    // Single page, full brightness
    page_seg   = {$urandom, $urandom, $urandom, 32'hB0A4F9C0};
    page_en    = 4'b0001;
    page_hold  = 1'b0;
    page_force = 1'b0;
    page_force_idx = 2'd0;
    blink_mask = 4'b0000;
    bright     = 3'd7;
    reset      = 1'b0;
    step(1);
    chk("first_tick", 32'(page_tick), 32'd1);
    step(40);
    chk("d1_an", 32'(an), 32'h0000000D);
    chk("d1_seg", 32'(seg), 32'h000000F9);
    step(300);

    // Three-page rotation, then hold
    page_en = 4'b1011;
    step(700);
    page_hold = 1'b1;
    step(300);
    page_hold = 1'b0;
    step(100);

    // Disable the page on display mid-dwell
    w = 0;
    while (cur_page !== 2'd1 && w < 1000) begin
      step(1);
      w++;
    end
    total++;
    assert (w < 1000) else begin
      bad++;
      $error("FAIL wait_page1 observed=%0d expected=1 within 1000 cycles", cur_page);
    end
    step(50);
    page_en = 4'b1001;
    step(1);
    chk("dis_page", 32'(cur_page), 32'd3);
    chk("dis_tick", 32'(page_tick), 32'd1);
    step(20);
    page_en = 4'b0000;
    step(1);
    chk("idle_valid", 32'(page_valid), 32'd0);
    step(1);
    chk("idle_an", 32'(an), 32'h0000000F);
    step(30);
    page_en = 4'b0100;
    step(1);
    chk("wake_page", 32'(cur_page), 32'd2);
    chk("wake_tick", 32'(page_tick), 32'd1);
    step(60);

    // Forced page
    page_en = 4'b0001;
    step(10);
    page_force = 1'b1;
    page_force_idx = 2'd2;
    step(1);
    chk("force_page", 32'(cur_page), 32'd2);
    chk("force_tick", 32'(page_tick), 32'd1);
    step(300);
    chk("force_hold", 32'(cur_page), 32'd2);
    page_force_idx = 2'd3;
    step(1);
    chk("force_idx_page", 32'(cur_page), 32'd3);
    step(20);
    page_force = 1'b0;
    step(1);
    chk("release_page", 32'(cur_page), 32'd0);
    chk("release_tick", 32'(page_tick), 32'd1);
    step(100);

    // Brightness and blink
    page_en = 4'b0011;
    bright  = 3'd1;
    step(400);
    blink_mask = 4'b0010;
    step(400);
    bright = 3'd7;
    step(300);

    // Randomized phases with a mid-run reset
    for (int r = 0; r < 60; r++) begin
      rand_inputs();
      if ($urandom_range(0, 3) != 0) page_force = 1'b0;
      if ($urandom_range(0, 2) != 0) page_hold = 1'b0;
      if (r == 30) begin
        reset = 1'b1;
        step(2);
        reset = 1'b0;
      end
      step(50 + $urandom_range(0, 150));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
